// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared states and constants for the program loader
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PAD,
    DONE,
    ERR
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int LANE_W = $clog2(WORD_BYTES);
  localparam logic [7:0] DEFAULT_PAD_BYTE = 8'h00;

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream handshake feeding the loader
interface prog_loader_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;

  modport master (output in_valid, in_data, in_last, input in_ready);
  modport slave (input in_valid, in_data, in_last, output in_ready);

endinterface

// File: rtl/prog_loader_word_assembler.sv
// rtl/prog_loader_word_assembler.sv - packs written bytes into big-endian words
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        clear,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  output logic        word_valid,
  output logic [31:0] word
);

  // Only the three older bytes are kept; the fourth arrives with wr_data.
  logic [23:0]       shift;
  logic [LANE_W-1:0] lane;

  // Shift bytes in and publish a word on the cycle its last byte is written.
  always_ff @(posedge clk) begin
    if (clr || clear) begin
      shift      <= '0;
      lane       <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (wr_en) begin
        shift <= {shift[15:0], wr_data};
        lane  <= lane + LANE_W'(1);
        if (lane == LANE_W'(WORD_BYTES - 1)) begin
          word_valid <= 1'b1;
          word       <= {shift, wr_data};
        end
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a program image into CPU RAM and releases CPU reset
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W   = 8,
  parameter logic [7:0] PAD_BYTE = DEFAULT_PAD_BYTE
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  prog_loader_if.slave      src,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              word_valid,
  output logic [31:0]       word,
  output logic [ADDR_W:0]   byte_count,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr;
  logic              accept;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              start_taken;
  logic              at_boundary;

  // The byte being written now closes a word.
  assign at_boundary = (ptr[LANE_W-1:0] == LANE_W'(WORD_BYTES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; the byte at the top address without last overflows.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        if (accept) begin
          if (src.in_last)   state_d = at_boundary ? DONE : PAD;
          else if (&ptr)     state_d = ERR;
        end
      end
      PAD:  if (at_boundary) state_d = DONE;
      DONE: if (start) state_d = LOAD;
      ERR:  if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and write-source selection; in_ready depends only on state.
  always_comb begin
    src.in_ready = (state_q == LOAD);
    accept       = (state_q == LOAD) && src.in_valid;
    wr_en        = accept || (state_q == PAD);
    wr_data      = (state_q == PAD) ? PAD_BYTE : src.in_data;
    start_taken  = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
  end

  // Registered RAM write port, counters, and CPU release status.
  always_ff @(posedge clk) begin
    if (clr) begin
      ptr        <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      byte_count <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      mem_we <= wr_en;
      if (wr_en) begin
        mem_addr   <= ptr;
        mem_wdata  <= wr_data;
        ptr        <= ptr + ADDR_W'(1);
        byte_count <= byte_count + (ADDR_W + 1)'(1);
      end
      if (start_taken) begin
        ptr        <= '0;
        byte_count <= '0;
        cpu_hold   <= 1'b1;
        load_done  <= 1'b0;
        load_err   <= 1'b0;
      end else begin
        // Lags DONE by one cycle so the final write has landed before release.
        cpu_hold  <= (state_q != DONE);
        load_done <= (state_q == DONE);
        load_err  <= (state_q == ERR);
      end
    end
  end

  word_assembler u_word_assembler (
    .clk        (clk),
    .clr        (clr),
    .clear      (start_taken),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .word_valid (word_valid),
    .word       (word)
  );

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader
module tb_prog_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              clr;
  logic              start;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              word_valid;
  logic [31:0]       word;
  logic [ADDR_W:0]   byte_count;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  prog_loader_if bus ();

  prog_loader #(.ADDR_W(ADDR_W), .PAD_BYTE(8'h00)) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .src        (bus),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .word_valid (word_valid),
    .word       (word),
    .byte_count (byte_count),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [ADDR_W+7:0] exp_wr_q[$];
  logic [31:0]       exp_word_q[$];
  logic [ADDR_W+7:0] e_wr;
  logic [31:0]       e_word;

  int          m_ptr;
  int          m_lane;
  logic [31:0] m_shift;

  typedef struct {
    int         len;
    logic [7:0] base;
    bit         last;
    int         gap_max;
    bit         exp_done;
    int         exp_count;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_lane  = 0;
    m_shift = '0;
  endtask

  task automatic model_write(input logic [7:0] d);
    exp_wr_q.push_back({ADDR_W'(m_ptr), d});
    m_shift = {m_shift[23:0], d};
    m_lane++;
    if (m_lane == 4) begin
      exp_word_q.push_back(m_shift);
      m_lane = 0;
    end
    m_ptr++;
  endtask

  // Scoreboard: every RAM write and every completed word must match the model in order.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL write_extra actual=%0h required=none", {mem_addr, mem_wdata});
      end else begin
        e_wr = exp_wr_q.pop_front();
        check("write_addr_data", {48'h0, mem_addr, mem_wdata}, {48'h0, e_wr});
      end
    end
    if (word_valid === 1'b1) begin
      if (exp_word_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL word_extra actual=%0h required=none", word);
      end else begin
        e_word = exp_word_q.pop_front();
        check("word", {32'h0, word}, {32'h0, e_word});
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_cpu_hold"}, cpu_hold, 1);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_word_valid"}, word_valid, 0);
    check({tag, "_word"}, word, 0);
    check({tag, "_byte_count"}, byte_count, 0);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_load_err"}, load_err, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns just after the edge that accepted the byte, in_valid still high.
  task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
    int guard;
    guard = 0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (bus.in_ready !== 1'b1 && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 20) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout actual=0 required=1");
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_write(d);
    if (l) while (m_ptr % 4 != 0) model_write(8'h00);
  endtask

  task automatic end_stream();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_end(input string tag, input bit exp_done, input int exp_count);
    int guard;
    guard = 0;
    while (load_done !== 1'b1 && load_err !== 1'b1 && guard < 40) begin
      guard++;
      @(negedge clk);
    end
    check({tag, "_load_done"}, load_done, exp_done);
    check({tag, "_load_err"}, load_err, !exp_done);
    check({tag, "_cpu_hold"}, cpu_hold, !exp_done);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_byte_count"}, byte_count, exp_count);
    check({tag, "_pending"}, exp_wr_q.size() + exp_word_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    model_reset();

    vecs[0] = '{8,   8'h01, 1'b1, 0, 1'b1, 8,   32'h05060708};
    vecs[1] = '{6,   8'hA0, 1'b1, 0, 1'b1, 8,   32'hA4A50000};
    vecs[2] = '{256, 8'h10, 1'b0, 0, 1'b0, 256, 32'h0C0D0E0F};
    vecs[3] = '{256, 8'h33, 1'b1, 0, 1'b1, 256, 32'h2F303132};
    vecs[4] = '{13,  8'h50, 1'b1, 3, 1'b1, 16,  32'h5C000000};
    vecs[5] = '{1,   8'hEE, 1'b1, 2, 1'b1, 4,   32'hEE000000};

    repeat (3) @(negedge clk);
    check_reset("reset");
    clr = 1'b0;

    // Release timing: CPU stays held while the last byte is written, then drops.
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1), i == 7, 0);
    @(negedge clk);
    check("rel_mem_we", mem_we, 1);
    check("rel_mem_addr", mem_addr, 7);
    check("rel_hold_during_write", cpu_hold, 1);
    check("rel_done_during_write", load_done, 0);
    @(negedge clk);
    check("rel_hold_after", cpu_hold, 0);
    check("rel_done_after", load_done, 1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    wait_end("rel", 1'b1, 8);

    // Table of images, each starting from the previous DONE or ERR state.
    for (int v = 0; v < 6; v++) begin
      pulse_start();
      check($sformatf("v%0d_start_hold", v), cpu_hold, 1);
      check($sformatf("v%0d_start_done", v), load_done, 0);
      check($sformatf("v%0d_start_err", v), load_err, 0);
      check($sformatf("v%0d_start_count", v), byte_count, 0);
      check($sformatf("v%0d_start_ready", v), bus.in_ready, 1);
      for (int i = 0; i < vecs[v].len; i++)
        send_byte(8'(int'(vecs[v].base) + i), vecs[v].last && (i == vecs[v].len - 1),
                  vecs[v].gap_max > 0 ? int'($urandom_range(vecs[v].gap_max, 0)) : 0);
      end_stream();
      wait_end($sformatf("v%0d", v), vecs[v].exp_done, vecs[v].exp_count);
      check($sformatf("v%0d_last_word", v), word, vecs[v].exp_word);
    end

    // start while loading is ignored: the image continues contiguously.
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(8'(8'hC0 + i), 1'b0, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mid_start_ready", bus.in_ready, 1);
    check("mid_start_count", byte_count, 3);
    check("mid_start_hold", cpu_hold, 1);
    send_byte(8'hC3, 1'b1, 0);
    end_stream();
    wait_end("mid_start", 1'b1, 4);
    check("mid_start_word", word, 32'hC0C1C2C3);

    // clr in the middle of a load, then reload from address 0.
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h70 + i), 1'b0, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_reset("clr_mid");
    check("clr_pending", exp_wr_q.size() + exp_word_q.size(), 0);
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(8'(8'h90 + i), i == 3, 1);
    end_stream();
    wait_end("reload", 1'b1, 4);
    check("reload_word", word, 32'h90919293);

    repeat (5) @(negedge clk);
    check("final_pending", exp_wr_q.size() + exp_word_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
